addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised multi-cycle add/subtract unit, the successor to the fixed 32-bit combinational subtractor in the ALU datapath. It processes operands CHUNK bits per clock, LSB-first, through a registered carry chain, and reports the result plus status flags under a start/done handshake. It sits beside the ALU as the long-word arithmetic path, where a full-width combinational carry chain would not meet timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; honoured only when busy=0.
- op  in  1  0 = add (A+B), 1 = subtract (A−B).
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse; result and flags valid.
- result  out  WIDTH  sum/difference, two's complement.
- carry  out  1  carry out of MSB; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].

## Operation
- N = WIDTH/CHUNK chunk steps per operation.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, op, and b (or ~b when op=1), set carry register to op, clear chunk index, set busy → RUN.
  - RUN: each cycle, add chunk[idx] of A and B' with carry register; write sum chunk into result[idx*CHUNK +: CHUNK]; update carry register; idx++. After chunk N−1 → DONE.
  - DONE: done=1, busy=0, flags valid. Next cycle → IDLE, or straight to RUN if start=1 (back-to-back accepted).
- start is ignored while busy=1; operands are not re-sampled.
- overflow = carry into MSB XOR carry out of MSB, taken from the final chunk.
- zero and negative are evaluated on the full assembled result.
- result and flags hold their last values until the next accepted start, when result is overwritten chunk by chunk.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: busy=0, done=0, result=0, carry=0, overflow=0, zero=0, negative=0; state=IDLE.
- start sampled at edge k → busy=1 after edge k; chunks computed at edges k+1..k+N; done=1 for the cycle following edge k+N.
- Latency start→done = N+1 edges. With the defaults, N=4.
- CHUNK=WIDTH gives N=1, which is a legal single-step case.
- rst_n asserted mid-operation aborts immediately: all outputs go to their reset values, and no done pulse is issued.
- Throughput: one operation per N+1 cycles with back-to-back start.

## Configuration
- ADDSUB_FLAGS_EN defined: carry/overflow/zero/negative are computed as above.
- Not defined: the flag ports remain present but are tied to 0, and the flag logic is removed. result, busy, and done are unchanged.

## Structure
- Shared package `addsub_pkg`:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - State encoding S_IDLE/S_RUN/S_DONE.
  - Chunk-count helper constant.
- Sub-module `addsub_chunk`: combinational CHUNK-bit adder slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the slice MSB, used for overflow).
  - Instantiated once and reused each cycle.

## Test plan
All cases use the defaults (WIDTH=32, CHUNK=8).
- sub 7−32 → result 0xFFFFFFE7, negative=1, carry=0, zero=0, overflow=0; done exactly 5 edges after start.
- sub 15−16 → 0xFFFFFFFF, negative=1, carry=0; sub 5−(−3) (b=0xFFFFFFFD) → 0x00000008, carry=0; sub 5−4 → 0x00000001, carry=1.
- add 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1; sub 5−5 → 0, zero=1, carry=1.
- start re-asserted with new operands during RUN → ignored, original result delivered. start held high in the DONE cycle → next operation begins, done spacing 5 cycles.
- rst_n pulsed low at the 2nd RUN cycle → all outputs 0 asynchronously, no done. A new start after release completes correctly.
- Without ADDSUB_FLAGS_EN: 0x7FFFFFFF+1 → result 0x80000000, all flags 0. Repeat the random add/sub sweep at CHUNK=1, 4, and 32 against a reference model.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants for the multi-cycle add/subtract unit.
// Op codes, FSM state encoding and the chunk-count helper.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic int chunk_count(input int w, input int c);
        return w / c;
    endfunction

    localparam int DEF_STEPS = chunk_count(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder slice.
// Also exposes the carry into the slice MSB for signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum    = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];

    if (CHUNK == 1) begin : g_one
        assign c_msb = cin;
    end else begin : g_multi
        logic [CHUNK-1:0] w_low;
        assign w_low = {1'b0, a[CHUNK-2:0]}
                     + {1'b0, b[CHUNK-2:0]}
                     + {{(CHUNK-1){1'b0}}, cin};
        assign c_msb = w_low[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: LSB-first chunked add/subtract with start/done handshake.
// Status flags are built only when ADDSUB_FLAGS_EN is defined.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = chunk_count(WIDTH, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cy;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_result;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_last;

`ifdef ADDSUB_FLAGS_EN
    logic             w_cmsb;
`endif

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_state == S_RUN) && (r_idx == LAST);

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (w_a_chunk),
        .b     (w_b_chunk),
        .cin   (r_cy),
        .sum   (w_sum),
        .cout  (w_cout),
`ifdef ADDSUB_FLAGS_EN
        .c_msb (w_cmsb)
`else
        .c_msb ()
`endif
    );

    // FSM, operand capture and chunk-by-chunk result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cy     <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= (op == OP_SUB) ? ~b : b;
                        r_cy    <= op;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_result[r_idx*CHUNK +: CHUNK] <= w_sum;
                    r_cy  <= w_cout;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

`ifdef ADDSUB_FLAGS_EN
    logic [WIDTH-1:0] w_final;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Full result as it will stand after the final chunk is written
    always_comb begin
        w_final = r_result;
        w_final[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    // Flags captured on the final chunk, held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_last) begin
            r_carry <= w_cout;
            r_ovf   <= w_cmsb ^ w_cout;
            r_zero  <= (w_final == '0);
            r_neg   <= w_final[WIDTH-1];
        end
    end

    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = r_zero;
    assign negative = r_neg;
`else
    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: table vectors, corner sequences and a random sweep
// across CHUNK = 8, 1, 4, 32 with a queue-based scoreboard.
module tb_addsub_seq;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          c;
        bit          v;
        bit          z;
        bit          n;
    } vec_t;

    typedef struct {
        int          dut;
        logic [31:0] r;
        bit          c;
        bit          v;
        bit          z;
        bit          n;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  start_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  carry_v;
    logic [3:0]  ovf_v;
    logic [3:0]  zero_v;
    logic [3:0]  neg_v;
    logic [31:0] res_v [4];

    int   tests;
    int   fails;
    int   cyc;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        addsub_seq #(
            .WIDTH (32),
            .CHUNK (CH)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_v[g]),
            .op       (op_i),
            .a        (a_i),
            .b        (b_i),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .result   (res_v[g]),
            .carry    (carry_v[g]),
            .overflow (ovf_v[g]),
            .zero     (zero_v[g]),
            .negative (neg_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nof(input int d);
        case (d)
            0:       return 4;
            1:       return 32;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input bit op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] s;
        bb = op ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {32'd0, op};
        e.dut = 0;
        e.cyc = 0;
        e.r = s[31:0];
        e.c = FL & s[32];
        e.v = FL & (a[31] == bb[31]) & (s[31] != a[31]);
        e.z = FL & (s[31:0] == 32'd0);
        e.n = FL & s[31];
        return e;
    endfunction

    // Scoreboard: every done pulse pops and checks one expectation
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst_n && done_v[d]) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: dut %0d got done expected none", d);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_dut", 64'(d), 64'(mon_e.dut));
                    chk("result", 64'(res_v[d]), 64'(mon_e.r));
                    chk("flags cvzn",
                        64'({carry_v[d], ovf_v[d], zero_v[d], neg_v[d]}),
                        64'({mon_e.c, mon_e.v, mon_e.z, mon_e.n}));
                    chk("latency", 64'(cyc - mon_e.cyc), 64'(nof(d) + 1));
                    chk("busy_in_done", 64'(busy_v[d]), 64'd0);
                end
            end
        end
    end

    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[d] && n < 200);
        if (!done_v[d]) begin
            tests++;
            fails++;
            $display("FAIL timeout: dut %0d got no done expected done", d);
        end
    endtask

    task automatic drive(input int d, input exp_t e, input bit op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        x = e;
        x.dut = d;
        x.cyc = cyc;
        op_i = op;
        a_i = a;
        b_i = b;
        start_v[d] = 1'b1;
        sbq.push_back(x);
    endtask

    task automatic do_op(input int d, input exp_t e, input bit op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(d, e, op, a, b);
        @(negedge clk);
        start_v[d] = 1'b0;
        wait_done(d);
    endtask

    task automatic check_zero_outs(input string nm);
        chk(nm, 64'({busy_v[0], done_v[0], carry_v[0], ovf_v[0],
                     zero_v[0], neg_v[0]}), 64'd0);
        chk({nm, "_result"}, 64'(res_v[0]), 64'd0);
    endtask

    initial begin
        exp_t e;
        exp_t e2;
        int   t1;
        int   t2;
        int   seen;
        bit   op;
        logic [31:0] ra;
        logic [31:0] rb;

        tests = 0;
        fails = 0;
        cyc = 0;
        rst_n = 1'b0;
        start_v = '0;
        op_i = 1'b0;
        a_i = '0;
        b_i = '0;

        vt.push_back('{1, 32'd7,          32'd32,         32'hFFFFFFE7, 0, 0, 0, 1});
        vt.push_back('{1, 32'd15,         32'd16,         32'hFFFFFFFF, 0, 0, 0, 1});
        vt.push_back('{1, 32'd5,          32'hFFFFFFFD,   32'h00000008, 0, 0, 0, 0});
        vt.push_back('{1, 32'd5,          32'd4,          32'h00000001, 1, 0, 0, 0});
        vt.push_back('{0, 32'h7FFFFFFF,   32'd1,          32'h80000000, 0, 1, 0, 1});
        vt.push_back('{1, 32'd5,          32'd5,          32'h00000000, 1, 0, 1, 0});
        vt.push_back('{0, 32'hFFFFFFFF,   32'd1,          32'h00000000, 1, 0, 1, 0});
        vt.push_back('{1, 32'h80000000,   32'd1,          32'h7FFFFFFF, 1, 1, 0, 0});
        vt.push_back('{0, 32'h12345678,   32'h9ABCDEF0,   32'hACF13568, 0, 0, 0, 1});

        repeat (2) @(negedge clk);
        check_zero_outs("reset_state");
        rst_n = 1'b1;

        foreach (vt[i]) begin
            e.r = vt[i].r;
            e.c = FL & vt[i].c;
            e.v = FL & vt[i].v;
            e.z = FL & vt[i].z;
            e.n = FL & vt[i].n;
            do_op(0, e, vt[i].op, vt[i].a, vt[i].b);
        end

        // start during RUN must be ignored
        e = model(1'b0, 32'h11112222, 32'h33334444);
        @(negedge clk);
        drive(0, e, 1'b0, 32'h11112222, 32'h33334444);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        a_i = 32'hDEADBEEF;
        b_i = 32'h01010101;
        op_i = 1'b1;
        start_v[0] = 1'b1;
        chk("busy_run", 64'(busy_v[0]), 64'd1);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);

        // back-to-back: start held in the DONE cycle
        e = model(1'b1, 32'd1000, 32'd1);
        e2 = model(1'b0, 32'hFFFF0000, 32'h0001FFFF);
        @(negedge clk);
        drive(0, e, 1'b1, 32'd1000, 32'd1);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        t1 = cyc;
        drive(0, e2, 1'b0, 32'hFFFF0000, 32'h0001FFFF);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        t2 = cyc;
        chk("b2b_spacing", 64'(t2 - t1), 64'd5);

        // asynchronous reset in the second RUN cycle
        e = model(1'b0, 32'h0F0F0F0F, 32'h01010101);
        @(negedge clk);
        drive(0, e, 1'b0, 32'h0F0F0F0F, 32'h01010101);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero_outs("async_reset");
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0]) seen++;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);
        do_op(0, model(1'b1, 32'd100, 32'd58), 1'b1, 32'd100, 32'd58);

        // random sweep on every chunk size
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 12; k++) begin
                op = 1'($urandom_range(0, 1));
                ra = $urandom;
                rb = (k % 3 == 0) ? ra : $urandom;
                do_op(d, model(op, ra, rb), op, ra, rb);
            end
            do_op(d, model(1'b0, 32'h7FFFFFFF, 32'd1), 1'b0,
                  32'h7FFFFFFF, 32'd1);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
